// File: rtl/lpf_coef_ctrl.sv
// lpf_coef_ctrl: MIDI CC decoder and coefficient shadow/live bank controller
// for the LPF IIR datapath. CC writes land in a shadow bank; a commit copies
// the shadow bank to the live coefficient bus only while the filter is idle.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module lpf_coef_ctrl #(
  parameter int MIDI_CH    = 0,
  parameter int CC_BASE    = 20,
  parameter int CC_LSB_OFS = 32,
  parameter int CC_COMMIT  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      midi_rdy,
  input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]                midi_ch_sysn,
  input  logic [6:0]                midi_data0,
  input  logic [6:0]                midi_data1,
  input  logic                      sample_in_rdy,
  input  logic                      sample_out_rdy,
  output logic [89:0]               coefs_flat,
  output logic                      coefs_upd,
  output logic                      commit_pend
);

  // Q2.16 constants: coef0 is fixed at 1.0, coef1..coef4 have reset defaults
  localparam logic [17:0] COEF0     = 18'h10000;
  localparam logic [17:0] DEF_COEF1 = 18'h3F000;
  localparam logic [17:0] DEF_COEF2 = 18'h01000;
  localparam logic [17:0] DEF_COEF3 = 18'h3F000;
  localparam logic [17:0] DEF_COEF4 = 18'h01000;
  localparam logic [3:0][17:0] DEF_BANK = {DEF_COEF4, DEF_COEF3, DEF_COEF2, DEF_COEF1};

  // CC numbers widened to 8 bits so offset subtraction wraps cleanly
  localparam logic [3:0] MIDI_CH_L    = 4'(MIDI_CH);
  localparam logic [7:0] CC_MSB_L     = 8'(CC_BASE);
  localparam logic [7:0] CC_LSB_L     = 8'(CC_BASE + CC_LSB_OFS);
  localparam logic [7:0] CC_COMMIT_L  = 8'(CC_COMMIT);
  localparam logic [7:0] CC_RESET_ALL = 8'd121;
  localparam logic [`MIDI_CMD_SIZE-1:0] CMD_CC = `MIDI_CMD_CC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Map a 14-bit MSB/LSB pair (offset binary around 8192) to signed Q2.16:
  // flipping the top bit converts offset binary to two's complement, and the
  // four appended zeros scale the step to 16 LSBs.
  function automatic logic [17:0] cc_to_coef(input logic [6:0] msb, input logic [6:0] lsb);
    logic [13:0] v;
    v = {msb, lsb};
    return {~v[13], v[12:0], 4'b0000};
  endfunction

  logic [7:0]        cc_num_s;
  logic [7:0]        msb_off_s;
  logic [7:0]        lsb_off_s;
  logic              ev_acc_s;
  logic              msb_hit_s;
  logic              lsb_hit_s;
  logic              commit_hit_s;
  logic              reset_all_hit_s;
  logic [1:0]        msb_idx_s;
  logic [1:0]        lsb_idx_s;

  logic [3:0][17:0]  shadow_r;
  logic [3:0][17:0]  live_r;
  logic [3:0][6:0]   msb_reg_r;
  logic [3:0]        msb_valid_r;
  logic              commit_req_r;
  logic              busy_r;
  logic              coefs_upd_r;
  logic              commit_pend_r;

  state_t            state_r;
  state_t            state_next_s;
  logic              apply_s;
  logic              pend_s;

  // Decode an incoming MIDI event into MSB / LSB / commit / reset-all hits
  always_comb begin
    cc_num_s        = {1'b0, midi_data0};
    msb_off_s       = cc_num_s - CC_MSB_L;
    lsb_off_s       = cc_num_s - CC_LSB_L;
    msb_idx_s       = msb_off_s[1:0];
    lsb_idx_s       = lsb_off_s[1:0];
    ev_acc_s        = midi_rdy && (midi_cmd == CMD_CC) && (midi_ch_sysn == MIDI_CH_L);
    msb_hit_s       = ev_acc_s && (msb_off_s < 8'd4);
    lsb_hit_s       = ev_acc_s && (lsb_off_s < 8'd4);
    commit_hit_s    = ev_acc_s && (cc_num_s == CC_COMMIT_L);
    reset_all_hit_s = ev_acc_s && (cc_num_s == CC_RESET_ALL);
  end

  // Shadow bank and MSB staging registers written by accepted CC events
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r    <= DEF_BANK;
      msb_reg_r   <= '0;
      msb_valid_r <= 4'b0000;
    end else if (reset_all_hit_s) begin
      shadow_r    <= DEF_BANK;
      msb_valid_r <= 4'b0000;
    end else if (msb_hit_s) begin
      msb_reg_r[msb_idx_s]   <= midi_data1;
      msb_valid_r[msb_idx_s] <= 1'b1;
    end else if (lsb_hit_s && msb_valid_r[lsb_idx_s]) begin
      shadow_r[lsb_idx_s]    <= cc_to_coef(msb_reg_r[lsb_idx_s], midi_data1);
      msb_valid_r[lsb_idx_s] <= 1'b0;
    end else begin
      msb_valid_r <= msb_valid_r;
    end
  end

  // Register commit requests (explicit commit CC or Reset All Controllers)
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_req_r <= 1'b0;
    end else begin
      commit_req_r <= commit_hit_s || reset_all_hit_s;
    end
  end

  // Track whether the filter is mid-sample; a start strobe wins over a finish
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else if (sample_in_rdy) begin
      busy_r <= 1'b1;
    end else if (sample_out_rdy) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Commit FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Commit FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (commit_req_r) begin
          state_next_s = PEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      PEND: begin
        if (!busy_r && !sample_in_rdy) begin
          state_next_s = APPLY;
        end else begin
          state_next_s = PEND;
        end
      end
      APPLY: begin
        // A sample starting in the APPLY cycle defers the copy so the live
        // bus never moves under a running sample; a new request re-arms PEND.
        if (commit_req_r || sample_in_rdy) begin
          state_next_s = PEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Commit FSM outputs: copy strobe and pending indication
  always_comb begin
    apply_s = 1'b0;
    pend_s  = 1'b0;
    case (state_r)
      APPLY: begin
        apply_s = !sample_in_rdy;
      end
      default: begin
        apply_s = 1'b0;
      end
    endcase
    if (state_next_s != IDLE) begin
      pend_s = 1'b1;
    end else begin
      pend_s = 1'b0;
    end
  end

  // Live bank and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      live_r        <= DEF_BANK;
      coefs_upd_r   <= 1'b0;
      commit_pend_r <= 1'b0;
    end else begin
      if (apply_s) begin
        live_r <= shadow_r;
      end
      coefs_upd_r   <= apply_s;
      commit_pend_r <= pend_s;
    end
  end

  assign coefs_flat  = {live_r, COEF0};
  assign coefs_upd   = coefs_upd_r;
  assign commit_pend = commit_pend_r;

endmodule

// File: tb/tb_lpf_coef_ctrl.sv
// Directed testbench for lpf_coef_ctrl: CC decoding, commit latency,
// busy-gated commits, ignore cases and reset behaviour.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module tb_lpf_coef_ctrl;

  localparam logic [`MIDI_CMD_SIZE-1:0] CMD_CC   = `MIDI_CMD_CC;
  localparam logic [`MIDI_CMD_SIZE-1:0] CMD_NOTE = CMD_CC ^ 1'b1;
  localparam logic [89:0] DEFAULTS = {18'h01000, 18'h3F000, 18'h01000, 18'h3F000, 18'h10000};

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      midi_rdy;
  logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]                midi_ch_sysn;
  logic [6:0]                midi_data0;
  logic [6:0]                midi_data1;
  logic                      sample_in_rdy;
  logic                      sample_out_rdy;
  logic [89:0]               coefs_flat;
  logic                      coefs_upd;
  logic                      commit_pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lpf_coef_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .midi_rdy       (midi_rdy),
    .midi_cmd       (midi_cmd),
    .midi_ch_sysn   (midi_ch_sysn),
    .midi_data0     (midi_data0),
    .midi_data1     (midi_data1),
    .sample_in_rdy  (sample_in_rdy),
    .sample_out_rdy (sample_out_rdy),
    .coefs_flat     (coefs_flat),
    .coefs_upd      (coefs_upd),
    .commit_pend    (commit_pend)
  );

  function automatic logic [89:0] pack(input logic [17:0] c1, input logic [17:0] c2,
                                       input logic [17:0] c3, input logic [17:0] c4);
    return {c4, c3, c2, c1, 18'h10000};
  endfunction

  // advance one clock and settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [3:0] ch, input logic [`MIDI_CMD_SIZE-1:0] cmd,
                         input logic [6:0] d0, input logic [6:0] d1);
    midi_rdy = 1'b1; midi_ch_sysn = ch; midi_cmd = cmd; midi_data0 = d0; midi_data1 = d1;
    step();
    midi_rdy = 1'b0;
  endtask

  task automatic send_cc(input logic [6:0] d0, input logic [6:0] d1);
    send_ev(4'd0, CMD_CC, d0, d1);
  endtask

  // commit with the filter idle; returns at the cycle the update is visible
  task automatic commit_wait();
    send_cc(7'd24, 7'd0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL reset_coefs: got %h expected %h", coefs_flat, DEFAULTS); end
    checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b expected 0", coefs_upd); end
    checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", commit_pend); end
  endtask

  task automatic test_commit_latency();
    logic [89:0] exp_new;
    exp_new = pack(18'h1FFF0, 18'h01000, 18'h3F000, 18'h01000);
    send_cc(7'd20, 7'h7F);
    send_cc(7'd52, 7'h7F);
    send_cc(7'd24, 7'h00);   // edge N; now at N+1ns
    step();                  // N+1
    checks++; if (commit_pend !== 1'b1) begin errors++; $display("FAIL lat_pend_n1: got %b expected 1", commit_pend); end
    checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL lat_upd_n1: got %b expected 0", coefs_upd); end
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL lat_coefs_n1: got %h expected %h", coefs_flat, DEFAULTS); end
    step();                  // N+2
    checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL lat_upd_n2: got %b expected 0", coefs_upd); end
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL lat_coefs_n2: got %h expected %h", coefs_flat, DEFAULTS); end
    step();                  // N+3
    checks++; if (coefs_upd !== 1'b1) begin errors++; $display("FAIL lat_upd_n3: got %b expected 1", coefs_upd); end
    checks++; if (coefs_flat !== exp_new) begin errors++; $display("FAIL lat_coefs_n3: got %h expected %h", coefs_flat, exp_new); end
    checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL lat_pend_n3: got %b expected 0", commit_pend); end
    step();                  // N+4
    checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL lat_upd_n4: got %b expected 0", coefs_upd); end
  endtask

  task automatic test_coef_values();
    logic [89:0] exp_v;
    exp_v = pack(18'h1FFF0, 18'h00000, 18'h3F800, 18'h01000);
    send_cc(7'd21, 7'h40);
    send_cc(7'd53, 7'h00);
    send_cc(7'd22, 7'h3F);
    send_cc(7'd54, 7'h00);
    commit_wait();
    checks++; if (coefs_flat !== exp_v) begin errors++; $display("FAIL coef_values: got %h expected %h", coefs_flat, exp_v); end
    checks++; if (coefs_upd !== 1'b1) begin errors++; $display("FAIL coef_values_upd: got %b expected 1", coefs_upd); end
  endtask

  task automatic test_msb_overwrite();
    logic [89:0] exp_v;
    exp_v = pack(18'h1FFF0, 18'h1FFF0, 18'h3F800, 18'h20000);
    send_cc(7'd21, 7'h10);
    send_cc(7'd21, 7'h7F);   // second MSB replaces the first
    send_cc(7'd53, 7'h7F);
    send_cc(7'd23, 7'h00);   // most negative code
    send_cc(7'd55, 7'h00);
    commit_wait();
    checks++; if (coefs_flat !== exp_v) begin errors++; $display("FAIL msb_overwrite: got %h expected %h", coefs_flat, exp_v); end
  endtask

  task automatic test_busy_hold();
    logic [89:0] exp_old;
    logic [89:0] exp_new;
    logic [89:0] exp_c;
    exp_old = pack(18'h1FFF0, 18'h1FFF0, 18'h3F800, 18'h20000);
    exp_new = pack(18'h1FFF0, 18'h1FFF0, 18'h1FFF0, 18'h20000);
    send_cc(7'd22, 7'h7F);
    send_cc(7'd54, 7'h7F);
    for (int i = 0; i < 24; i++) begin
      sample_in_rdy  = (i == 0);
      sample_out_rdy = (i == 20);
      midi_rdy = (i == 2); midi_ch_sysn = 4'd0; midi_cmd = CMD_CC; midi_data0 = 7'd24; midi_data1 = 7'd0;
      step();
      exp_c = (i >= 22) ? exp_new : exp_old;
      checks++; if (coefs_flat !== exp_c) begin errors++; $display("FAIL busy_coefs[%0d]: got %h expected %h", i, coefs_flat, exp_c); end
      checks++; if (coefs_upd !== (i == 22)) begin errors++; $display("FAIL busy_upd[%0d]: got %b expected %b", i, coefs_upd, (i == 22)); end
      checks++; if (commit_pend !== (i >= 3 && i <= 21)) begin errors++; $display("FAIL busy_pend[%0d]: got %b expected %b", i, commit_pend, (i >= 3 && i <= 21)); end
    end
    sample_in_rdy = 1'b0; sample_out_rdy = 1'b0; midi_rdy = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [89:0] exp_old;
    logic [89:0] exp_new;
    logic [89:0] exp_c;
    exp_old = pack(18'h1FFF0, 18'h1FFF0, 18'h1FFF0, 18'h20000);
    exp_new = pack(18'h20010, 18'h1FFF0, 18'h1FFF0, 18'h20000);
    send_cc(7'd20, 7'h00);
    send_cc(7'd52, 7'h01);
    for (int i = 0; i < 14; i++) begin
      sample_in_rdy  = (i == 0);
      sample_out_rdy = (i == 10);
      midi_rdy = (i == 0); midi_ch_sysn = 4'd0; midi_cmd = CMD_CC; midi_data0 = 7'd24; midi_data1 = 7'd0;
      step();
      exp_c = (i >= 12) ? exp_new : exp_old;
      checks++; if (coefs_flat !== exp_c) begin errors++; $display("FAIL same_coefs[%0d]: got %h expected %h", i, coefs_flat, exp_c); end
      checks++; if (coefs_upd !== (i == 12)) begin errors++; $display("FAIL same_upd[%0d]: got %b expected %b", i, coefs_upd, (i == 12)); end
      checks++; if (commit_pend !== (i >= 1 && i <= 11)) begin errors++; $display("FAIL same_pend[%0d]: got %b expected %b", i, commit_pend, (i >= 1 && i <= 11)); end
    end
    sample_in_rdy = 1'b0; sample_out_rdy = 1'b0; midi_rdy = 1'b0;
  endtask

  task automatic test_ignore();
    logic [89:0] exp_v;
    exp_v = pack(18'h20010, 18'h1FFF0, 18'h1FFF0, 18'h20000);
    send_cc(7'd55, 7'h7F);                  // LSB with no MSB
    send_ev(4'd3, CMD_CC, 7'd20, 7'h00);    // wrong channel
    send_ev(4'd3, CMD_CC, 7'd52, 7'h00);
    send_ev(4'd0, CMD_NOTE, 7'd21, 7'h00);  // not a CC
    send_ev(4'd0, CMD_NOTE, 7'd53, 7'h00);
    send_ev(4'd0, CMD_NOTE, 7'd24, 7'h00);  // non-CC commit number
    send_ev(4'd3, CMD_CC, 7'd24, 7'h00);    // commit on wrong channel
    repeat (3) step();
    checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL ignore_pend: got %b expected 0", commit_pend); end
    checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL ignore_upd: got %b expected 0", coefs_upd); end
    send_cc(7'd19, 7'h00);                  // outside recognised CC set
    send_cc(7'd56, 7'h00);
    send_cc(7'd51, 7'h00);
    commit_wait();
    checks++; if (coefs_flat !== exp_v) begin errors++; $display("FAIL ignore_coefs: got %h expected %h", coefs_flat, exp_v); end
    checks++; if (coefs_upd !== 1'b1) begin errors++; $display("FAIL ignore_commit_upd: got %b expected 1", coefs_upd); end
  endtask

  task automatic test_reset_pend();
    send_cc(7'd20, 7'h7F);
    send_cc(7'd52, 7'h7F);
    sample_in_rdy = 1'b1;
    step();
    sample_in_rdy = 1'b0;
    send_cc(7'd24, 7'h00);
    repeat (2) step();
    checks++; if (commit_pend !== 1'b1) begin errors++; $display("FAIL rstpend_before: got %b expected 1", commit_pend); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL rstpend_coefs: got %h expected %h", coefs_flat, DEFAULTS); end
    checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL rstpend_pend: got %b expected 0", commit_pend); end
    sample_out_rdy = 1'b1;
    step();
    sample_out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (coefs_upd !== 1'b0) begin errors++; $display("FAIL rstpend_upd[%0d]: got %b expected 0", i, coefs_upd); end
      checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL rstpend_hold[%0d]: got %h expected %h", i, coefs_flat, DEFAULTS); end
    end
  endtask

  task automatic test_reset_all();
    logic [89:0] exp_v;
    exp_v = pack(18'h3F000, 18'h1FFF0, 18'h3F000, 18'h01000);
    send_cc(7'd21, 7'h7F);
    send_cc(7'd53, 7'h7F);
    commit_wait();
    checks++; if (coefs_flat !== exp_v) begin errors++; $display("FAIL rall_custom: got %h expected %h", coefs_flat, exp_v); end
    send_cc(7'd20, 7'h55);                  // MSB staged, then discarded
    send_cc(7'd121, 7'h00);
    repeat (3) step();
    checks++; if (coefs_upd !== 1'b1) begin errors++; $display("FAIL rall_upd: got %b expected 1", coefs_upd); end
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL rall_coefs: got %h expected %h", coefs_flat, DEFAULTS); end
    send_cc(7'd52, 7'h00);                  // LSB after reset-all: no MSB valid
    commit_wait();
    checks++; if (coefs_flat !== DEFAULTS) begin errors++; $display("FAIL rall_msb_cleared: got %h expected %h", coefs_flat, DEFAULTS); end
  endtask

  initial begin
    reset = 1'b1; midi_rdy = 1'b0; midi_cmd = CMD_CC; midi_ch_sysn = 4'd0;
    midi_data0 = 7'd0; midi_data1 = 7'd0; sample_in_rdy = 1'b0; sample_out_rdy = 1'b0;
    step();
    test_reset();
    test_commit_latency();
    test_coef_values();
    test_msb_overwrite();
    test_busy_hold();
    test_same_cycle();
    test_ignore();
    test_reset_pend();
    test_reset_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
